// File: rtl/arb_pkg.sv
// Shared identifiers and defaults for the SRAM-style bus arbiter.
// Set the ARB_RR_EN macro to build the arbiter with round-robin tie-breaking.
package arb_pkg;

    localparam int   OT_DEPTH_DEFAULT = 4;
    localparam logic REQ_ID_INST      = 1'b0;
    localparam logic REQ_ID_DATA      = 1'b1;

endpackage

// File: rtl/arb_order_fifo.sv
// In-order FIFO of requester ids for transfers that are still outstanding.
// Pushes while full and pops while empty are ignored.
module arb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap for free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-style bus, with in-order response routing.
// ARB_RR_EN defined: round-robin tie-break; undefined: data side always wins ties.
module sram_bus_arbiter
    import arb_pkg::*;
#(
    parameter int OT_DEPTH = OT_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      inst_req,
    input  logic                      inst_wr,
    input  logic [1:0]                inst_size,
    input  logic [3:0]                inst_wstrb,
    input  logic [31:0]               inst_addr,
    input  logic [31:0]               inst_wdata,
    output logic                      inst_addr_ok,
    output logic                      inst_data_ok,
    output logic [31:0]               inst_rdata,

    input  logic                      data_req,
    input  logic                      data_wr,
    input  logic [1:0]                data_size,
    input  logic [3:0]                data_wstrb,
    input  logic [31:0]               data_addr,
    input  logic [31:0]               data_wdata,
    output logic                      data_addr_ok,
    output logic                      data_data_ok,
    output logic [31:0]               data_rdata,

    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [1:0]                mem_size,
    output logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_addr_ok,
    input  logic                      mem_data_ok,
    input  logic [31:0]               mem_rdata,

    output logic [$clog2(OT_DEPTH):0] ot_cnt
);

    logic lock;
    logic lock_id;
    logic sel;
    logic sel_req;
    logic tie_id;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic head;

`ifdef ARB_RR_EN
    // Holds the id that should win the next tie: whoever was not granted at the last push.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr <= REQ_ID_INST;
        end else if (push) begin
            rr_ptr <= ~sel;
        end
    end

    assign tie_id = rr_ptr;
`else
    assign tie_id = REQ_ID_DATA;
`endif

    always_comb begin
        sel = REQ_ID_INST;
        if (lock) begin
            sel = lock_id;
        end else if (inst_req && data_req) begin
            sel = tie_id;
        end else if (data_req) begin
            sel = REQ_ID_DATA;
        end
    end

    assign sel_req   = (sel == REQ_ID_DATA) ? data_req   : inst_req;
    assign mem_req   = sel_req && !full;
    assign mem_wr    = (sel == REQ_ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (sel == REQ_ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (sel == REQ_ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (sel == REQ_ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (sel == REQ_ID_DATA) ? data_wdata : inst_wdata;

    assign push = mem_req && mem_addr_ok;
    assign pop  = mem_data_ok && !empty;

    assign inst_addr_ok = push && (sel == REQ_ID_INST);
    assign data_addr_ok = push && (sel == REQ_ID_DATA);
    assign inst_data_ok = pop && (head == REQ_ID_INST);
    assign data_data_ok = pop && (head == REQ_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // A stalled request keeps the bus so its payload cannot change under the slave.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock    <= 1'b0;
            lock_id <= REQ_ID_INST;
        end else if (push) begin
            lock    <= 1'b0;
        end else if (mem_req) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

    arb_order_fifo #(
        .DEPTH (OT_DEPTH),
        .WIDTH (1)
    ) u_order_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (sel),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (ot_cnt)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter (OT_DEPTH=4); honours ARB_RR_EN when defined.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  ot_cnt;

    int total = 0;
    int bad   = 0;

`ifdef ARB_RR_EN
    localparam logic [31:0] FIRST_TIE_ADDR  = 32'h0000_0100;
    localparam logic [31:0] SECOND_TIE_ADDR = 32'h0000_0200;
    localparam logic        FIRST_HEAD_DATA = 1'b0;
`else
    localparam logic [31:0] FIRST_TIE_ADDR  = 32'h0000_0200;
    localparam logic [31:0] SECOND_TIE_ADDR = 32'h0000_0200;
    localparam logic        FIRST_HEAD_DATA = 1'b1;
`endif

    sram_bus_arbiter #(.OT_DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .ot_cnt       (ot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
    task automatic applyStimulus(input logic ireq, input logic dreq, input logic aok,
                                 input logic dok, input logic [31:0] rdata);
        inst_req    = ireq;
        data_req    = dreq;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = 4'hf;
        inst_addr  = 32'h0000_0100;
        inst_wdata = 32'hAAAA_0001;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_wstrb = 4'h3;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'hBBBB_0002;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_ot_cnt", 32'(ot_cnt), 32'd0);
        checkOutput("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        checkOutput("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] tie between requesters");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("tie1_mem_addr", mem_addr, FIRST_TIE_ADDR);
        checkOutput("tie1_data_addr_ok", 32'(data_addr_ok), 32'(FIRST_HEAD_DATA));
        checkOutput("tie1_inst_addr_ok", 32'(inst_addr_ok), 32'(!FIRST_HEAD_DATA));
        tick();
        checkOutput("tie_ot_cnt1", 32'(ot_cnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("tie2_mem_addr", mem_addr, SECOND_TIE_ADDR);
        checkOutput("tie2_mem_wdata", mem_wdata, 32'hBBBB_0002);
        checkOutput("tie2_mem_wstrb", 32'(mem_wstrb), 32'h3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hAA);
        checkOutput("tie_pop1_data_ok", 32'(data_data_ok), 32'(FIRST_HEAD_DATA));
        checkOutput("tie_pop1_inst_ok", 32'(inst_data_ok), 32'(!FIRST_HEAD_DATA));
        checkOutput("tie_pop1_rdata", data_rdata, 32'hAA);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBB);
        checkOutput("tie_pop2_data_ok", 32'(data_data_ok), 32'd1);
        checkOutput("tie_pop2_inst_ok", 32'(inst_data_ok), 32'd0);
        tick();
        checkOutput("tie_ot_cnt0", 32'(ot_cnt), 32'd0);

        $display("[TB] lock against late higher-priority request");
        inst_addr = 32'h0000_0300;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_c1_mem_req", 32'(mem_req), 32'd1);
        checkOutput("lock_c1_mem_addr", mem_addr, 32'h300);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_c2_mem_addr", mem_addr, 32'h300);
        checkOutput("lock_c2_mem_wr", 32'(mem_wr), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_c3_mem_addr", mem_addr, 32'h300);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lock_c4_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        checkOutput("lock_c4_data_addr_ok", 32'(data_addr_ok), 32'd0);
        tick();

        $display("[TB] in-order response routing");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_push_data_ok", 32'(data_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_push_inst_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        checkOutput("ord_ot_cnt3", 32'(ot_cnt), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        checkOutput("ord_r1_inst_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
        checkOutput("ord_r1_rdata", inst_rdata, 32'h11);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
        checkOutput("ord_r2_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
        checkOutput("ord_r2_rdata", data_rdata, 32'h22);
        checkOutput("ord_r2_inst_rdata", inst_rdata, 32'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h33);
        checkOutput("ord_r3_inst_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
        checkOutput("ord_r3_rdata", inst_rdata, 32'h33);
        tick();

        $display("[TB] spurious response");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
        checkOutput("spur_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick();
        checkOutput("spur_ot_cnt", 32'(ot_cnt), 32'd0);

        $display("[TB] full with same-cycle pop");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        checkOutput("full_ot_cnt4", 32'(ot_cnt), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
        checkOutput("full_mem_req", 32'(mem_req), 32'd0);
        checkOutput("full_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        checkOutput("full_inst_data_ok", 32'(inst_data_ok), 32'd1);
        tick();
        checkOutput("full_ot_cnt3", 32'(ot_cnt), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("full_resume_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        checkOutput("full_ot_cnt4b", 32'(ot_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h60 + 32'(i));
            checkOutput("drain_inst_ok", 32'(inst_data_ok), 32'd1);
            tick();
        end
        checkOutput("drain_ot_cnt", 32'(ot_cnt), 32'd0);

        $display("[TB] reset with transfers outstanding");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        checkOutput("rst2_ot_cnt2", 32'(ot_cnt), 32'd2);
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("rst2_mem_req", 32'(mem_req), 32'd0);
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
        checkOutput("rst2_ot_cnt0", 32'(ot_cnt), 32'd0);
        checkOutput("rst2_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst2_ot_cnt_after", 32'(ot_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
